step_pulse_gen: RTL and testbench

- Downstream of the IR-sensor direction sequencer. Consumes its `dir`/`en` pair and produces STEP/DIR signals for an external stepper driver.
- Applies a trapezoidal speed profile:
  - accelerates linearly in period from MAX_PERIOD to MIN_PERIOD while enabled;
  - decelerates back to MAX_PERIOD before stopping;
  - enforces a direction-setup delay before the first step.
- Keeps a wrapping signed step-position count for debug/telemetry.

---
 rtl/step_pulse_gen.sv | 117 +++++++++++
 tb/tb_step_pulse_gen.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_pulse_gen.sv
// step_pulse_gen: STEP/DIR generator with a trapezoidal period profile,
// a direction-setup delay before the first step, and a wrapping position count.
module step_pulse_gen #(
    parameter int              PW         = 16,
    parameter logic [PW-1:0]   MAX_PERIOD = 16'd20000,
    parameter logic [PW-1:0]   MIN_PERIOD = 16'd2000,
    parameter logic [PW-1:0]   ACC_STEP   = 16'd100,
    parameter logic [PW-1:0]   PULSE_W    = 16'd50,
    parameter logic [PW-1:0]   DIR_SETUP  = 16'd20
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        en,
    input  logic        dir,
    output logic        step,
    output logic        dir_out,
    output logic        busy,
    output logic        at_speed,
    output logic [15:0] pos
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SETUP = 2'd1;
    localparam logic [1:0] PULSE = 2'd2;
    localparam logic [1:0] GAP   = 2'd3;
    localparam logic [PW-1:0] SETUP_LAST = DIR_SETUP - 1'b1;
    localparam logic [PW-1:0] PULSE_LAST = PULSE_W - 1'b1;
    localparam logic [PW:0]   MAX_X      = {1'b0, MAX_PERIOD};
    localparam logic [PW:0]   ACC_FLOOR  = {1'b0, MIN_PERIOD} + {1'b0, ACC_STEP};

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] p_q, p_d, cnt_q, cnt_d;
    logic          step_q, step_d, dir_q, dir_d, busy_q, busy_d, at_speed_q, at_speed_d;
    logic [15:0]   pos_q, pos_d;
    logic          stop_req, rise;
    logic [PW:0]   p_up;

    always_comb begin
        stop_req = !en || (dir != dir_q);
        p_up     = {1'b0, p_q} + {1'b0, ACC_STEP};
        state_d  = state_q;
        p_d      = p_q;
        cnt_d    = cnt_q + 1'b1;
        step_d   = step_q;
        dir_d    = dir_q;
        rise     = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (en) begin
                    state_d = SETUP;
                    dir_d   = dir;
                    p_d     = MAX_PERIOD;
                end
            end
            SETUP: begin
                if (stop_req) state_d = IDLE;
                else if (cnt_q == SETUP_LAST) rise = 1'b1;
            end
            PULSE: begin
                if (cnt_q == PULSE_LAST) begin
                    state_d = GAP;
                    step_d  = 1'b0;
                end
            end
            default: begin
                // gap end lands exactly P cycles after the previous rise
                if (cnt_q == p_q - 1'b1) begin
                    if (!stop_req) begin
                        p_d  = ({1'b0, p_q} >= ACC_FLOOR) ? p_q - ACC_STEP : MIN_PERIOD;
                        rise = 1'b1;
                    end else if (p_up >= MAX_X) begin
                        state_d = IDLE;
                    end else begin
                        p_d  = p_up[PW-1:0];
                        rise = 1'b1;
                    end
                end
            end
        endcase
        if (rise) begin
            state_d = PULSE;
            step_d  = 1'b1;
            cnt_d   = '0;
        end
        pos_d      = rise ? (dir_q ? pos_q + 16'd1 : pos_q - 16'd1) : pos_q;
        busy_d     = state_d != IDLE;
        at_speed_d = (state_d == PULSE || state_d == GAP) && p_d == MIN_PERIOD;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= IDLE;
            p_q        <= MAX_PERIOD;
            cnt_q      <= '0;
            step_q     <= 1'b0;
            dir_q      <= 1'b1;
            busy_q     <= 1'b0;
            at_speed_q <= 1'b0;
            pos_q      <= '0;
        end else begin
            state_q    <= state_d;
            p_q        <= p_d;
            cnt_q      <= cnt_d;
            step_q     <= step_d;
            dir_q      <= dir_d;
            busy_q     <= busy_d;
            at_speed_q <= at_speed_d;
            pos_q      <= pos_d;
        end
    end

    assign step     = step_q;
    assign dir_out  = dir_q;
    assign busy     = busy_q;
    assign at_speed = at_speed_q;
    assign pos      = pos_q;
endmodule

// File: tb/tb_step_pulse_gen.sv
// tb_step_pulse_gen: scoreboard bench; tasks push expected rise spacing/pos/dir,
// the negedge monitor pops and compares on every STEP rise.
module tb_step_pulse_gen;
    typedef struct {
        int          gap;
        logic [15:0] pos;
        logic        dir;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e_m;
    logic        CLK = 1'b0, RSTn = 1'b0, en = 1'b0, dir = 1'b1;
    logic        step, dir_out, busy, at_speed;
    logic [15:0] pos;
    logic [15:0] exp_pos = 16'h0;
    logic        step_prev = 1'b0;
    int          cyc = 0, ref_cyc = 0, hi = 0, errors = 0, checks = 0;
    int          acc_gaps[7] = '{3, 40, 35, 30, 25, 20, 20};

    step_pulse_gen #(
        .PW(16), .MAX_PERIOD(16'd40), .MIN_PERIOD(16'd20), .ACC_STEP(16'd5),
        .PULSE_W(16'd4), .DIR_SETUP(16'd3)
    ) dut (
        .CLK(CLK), .RSTn(RSTn), .en(en), .dir(dir), .step(step), .dir_out(dir_out),
        .busy(busy), .at_speed(at_speed), .pos(pos)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    always @(negedge CLK) begin
        if (!RSTn) begin
            step_prev = 1'b0;
            hi = 0;
        end else begin
            if (step && !step_prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_step cyc=%0d pos=%h", cyc, pos);
                end else begin
                    e_m = exp_q.pop_front();
                    if (cyc - ref_cyc !== e_m.gap || pos !== e_m.pos || dir_out !== e_m.dir) begin
                        errors++;
                        $display("FAIL step_rise got gap=%0d pos=%h dir=%b want gap=%0d pos=%h dir=%b",
                                 cyc - ref_cyc, pos, dir_out, e_m.gap, e_m.pos, e_m.dir);
                    end
                end
                ref_cyc = cyc;
                hi = 0;
            end
            if (!step && step_prev) begin
                checks++;
                if (hi !== 4) begin
                    errors++;
                    $display("FAIL step_width got %0d want 4", hi);
                end
            end
            if (step) hi++;
            step_prev = step;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge CLK);
            #1;
        end
    endtask

    task automatic push(input int gap, input logic d);
        exp_pos = d ? exp_pos + 16'd1 : exp_pos - 16'd1;
        exp_q.push_back('{gap: gap, pos: exp_pos, dir: d});
    endtask

    task automatic go(input logic d);
        en = 1'b1;
        dir = d;
        ref_cyc = cyc + 1;
    endtask

    task automatic wait_drain(input int limit);
        for (int i = 0; i < limit && exp_q.size() != 0; i++) tick(1);
    endtask

    task automatic test_reset;
        RSTn = 1'b0;
        tick(2);
        checks++;
        if ({step, dir_out, busy, at_speed, pos} !== {4'b0100, 16'h0}) begin
            errors++;
            $display("FAIL reset_values got %b_%h want 0100_0000", {step, dir_out, busy, at_speed}, pos);
        end
        RSTn = 1'b1;
        tick(3);
        checks++;
        if (busy !== 1'b0 || step !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset busy=%b step=%b want 0 0", busy, step);
        end
    endtask

    task automatic test_accel;
        foreach (acc_gaps[i]) push(acc_gaps[i], 1'b1);
        go(1'b1);
        for (int i = 0; i < 300 && exp_q.size() > 3; i++) tick(1);
        checks++;
        if (at_speed !== 1'b0) begin
            errors++;
            $display("FAIL at_speed_early got %b want 0", at_speed);
        end
        wait_drain(400);
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL accel_drain left=%0d want 0", exp_q.size());
        end
        checks++;
        if (at_speed !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL at_speed_cruise got at_speed=%b busy=%b want 1 1", at_speed, busy);
        end
    endtask

    task automatic test_decel;
        en = 1'b0;
        push(20, 1'b1);
        push(25, 1'b1);
        push(30, 1'b1);
        wait_drain(300);
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL decel_drain left=%0d want 0", exp_q.size());
        end
        tick(34);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_before_stop got %b want 1", busy);
        end
        tick(1);
        checks++;
        if (busy !== 1'b0 || at_speed !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_stop got busy=%b at_speed=%b want 0 0", busy, at_speed);
        end
        tick(60);
        checks++;
        if (pos !== exp_pos) begin
            errors++;
            $display("FAIL pos_frozen got %h want %h", pos, exp_pos);
        end
    endtask

    task automatic test_reversal;
        foreach (acc_gaps[i]) push(acc_gaps[i], 1'b1);
        go(1'b1);
        wait_drain(400);
        dir = 1'b0;
        push(20, 1'b1);
        push(25, 1'b1);
        push(30, 1'b1);
        push(39, 1'b0);
        push(40, 1'b0);
        for (int i = 0; i < 300 && exp_q.size() > 2; i++) tick(1);
        tick(35);
        checks++;
        if (busy !== 1'b0 || dir_out !== 1'b1) begin
            errors++;
            $display("FAIL reversal_idle got busy=%b dir_out=%b want 0 1", busy, dir_out);
        end
        tick(1);
        checks++;
        if (busy !== 1'b1 || dir_out !== 1'b0) begin
            errors++;
            $display("FAIL reversal_setup got busy=%b dir_out=%b want 1 0", busy, dir_out);
        end
        wait_drain(200);
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL reversal_drain left=%0d want 0", exp_q.size());
        end
        en = 1'b0;
        tick(40);
        checks++;
        if (busy !== 1'b0 || dir_out !== 1'b0) begin
            errors++;
            $display("FAIL reversal_stop got busy=%b dir_out=%b want 0 0", busy, dir_out);
        end
    endtask

    task automatic test_abort_setup;
        int nb;
        nb = 0;
        en = 1'b1;
        dir = 1'b1;
        tick(1);
        nb += int'(busy);
        tick(1);
        nb += int'(busy);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            nb += int'(busy);
        end
        checks++;
        if (nb < 1 || nb > 3) begin
            errors++;
            $display("FAIL abort_busy_cycles got %0d want 1..3", nb);
        end
        checks++;
        if (pos !== exp_pos || dir_out !== 1'b1) begin
            errors++;
            $display("FAIL abort_state got pos=%h dir_out=%b want %h 1", pos, dir_out, exp_pos);
        end
    endtask

    task automatic test_resume;
        for (int i = 0; i < 5; i++) push(acc_gaps[i], 1'b1);
        go(1'b1);
        wait_drain(300);
        en = 1'b0;
        push(20, 1'b1);
        push(25, 1'b1);
        wait_drain(200);
        en = 1'b1;
        push(30, 1'b1);
        push(25, 1'b1);
        push(20, 1'b1);
        push(20, 1'b1);
        wait_drain(300);
        checks++;
        if (exp_q.size() !== 0 || at_speed !== 1'b1) begin
            errors++;
            $display("FAIL resume_cruise left=%0d at_speed=%b want 0 1", exp_q.size(), at_speed);
        end
        en = 1'b0;
        push(20, 1'b1);
        push(25, 1'b1);
        push(30, 1'b1);
        wait_drain(300);
        tick(40);
        checks++;
        if (busy !== 1'b0 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL resume_stop got busy=%b left=%0d want 0 0", busy, exp_q.size());
        end
    endtask

    task automatic test_reset_mid;
        push(3, 1'b1);
        go(1'b1);
        wait_drain(50);
        checks++;
        if (step !== 1'b1) begin
            errors++;
            $display("FAIL step_before_reset got %b want 1", step);
        end
        RSTn = 1'b0;
        #1;
        checks++;
        if ({step, busy, at_speed, dir_out, pos} !== {4'b0001, 16'h0}) begin
            errors++;
            $display("FAIL reset_async got %b_%h want 0001_0000", {step, busy, at_speed, dir_out}, pos);
        end
        en = 1'b0;
        exp_pos = 16'h0;
        tick(3);
        RSTn = 1'b1;
        tick(60);
        checks++;
        if (busy !== 1'b0 || pos !== 16'h0) begin
            errors++;
            $display("FAIL after_reset_quiet got busy=%b pos=%h want 0 0000", busy, pos);
        end
    endtask

    task automatic test_wrap;
        push(3, 1'b0);
        go(1'b0);
        wait_drain(50);
        en = 1'b0;
        tick(45);
        checks++;
        if (pos !== 16'hFFFF || busy !== 1'b0) begin
            errors++;
            $display("FAIL wrap_bw got pos=%h busy=%b want ffff 0", pos, busy);
        end
        force dut.pos_q = 16'h7FFF;
        tick(2);
        release dut.pos_q;
        exp_pos = 16'h7FFF;
        tick(1);
        push(3, 1'b1);
        go(1'b1);
        wait_drain(50);
        en = 1'b0;
        tick(45);
        checks++;
        if (pos !== 16'h8000 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL wrap_fw got pos=%h left=%0d want 8000 0", pos, exp_q.size());
        end
    endtask

    initial begin
        tick(1);
        test_reset;
        test_accel;
        test_decel;
        test_reversal;
        test_abort_setup;
        test_resume;
        test_reset_mid;
        test_wrap;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end
endmodule
